// File: rtl/async_cnt_pkg.sv
// Shared constants and helpers for the ripple up-counter.
// JK input encodings, the jk_t bundle type and an all-ones mask helper.
package async_cnt_pkg;

  typedef logic [1:0] jk_t;

  localparam jk_t JK_HOLD   = 2'b00;
  localparam jk_t JK_RESET  = 2'b01;
  localparam jk_t JK_SET    = 2'b10;
  localparam jk_t JK_TOGGLE = 2'b11;

  function automatic logic [15:0] all_ones(input int unsigned width);
    return 16'((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/async_nbit_up_counter_jk_ff.sv
// Negedge JK flop with async reset, clear and preset (all active-low).
// Ports: clk, rst_n, j, k, pre_n, clr_n -> q, qbar (qbar = ~q, same flop).
module jk_ff
  import async_cnt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  input  logic pre_n,
  input  logic clr_n,
  output logic q,
  output logic qbar
);

  logic q_q;
  jk_t  jk;

  assign jk = {j, k};

  always_ff @(negedge clk or negedge rst_n
              or negedge clr_n or negedge pre_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (!clr_n) begin
      q_q <= 1'b0;
    end else if (!pre_n) begin
      q_q <= 1'b1;
    end else begin
      unique case (jk)
        JK_HOLD:   q_q <= q_q;
        JK_RESET:  q_q <= 1'b0;
        JK_SET:    q_q <= 1'b1;
        JK_TOGGLE: q_q <= ~q_q;
      endcase
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/async_nbit_up_counter.sv
// Ripple up-counter of WIDTH JK toggle stages plus clk-domain q_sync/wrap.
// Ports: clk, rst_n, count_en -> q, qbar, q_sync, wrap. Macro ASYNC_CNT_LOAD_EN adds load, load_val.
module async_nbit_up_counter
  import async_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_en,
`ifdef ASYNC_CNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] q_sync,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] stg_clk;
  logic [WIDTH-1:0] stg_jk;
  logic [WIDTH-1:0] pre_n;
  logic [WIDTH-1:0] clr_n;

`ifdef ASYNC_CNT_LOAD_EN
  // Level-sensitive load: each stage is forced to its bit while load=1.
  assign pre_n = ~({WIDTH{load}} & load_val);
  assign clr_n = ~({WIDTH{load}} & ~load_val);
`else
  assign pre_n = '1;
  assign clr_n = '1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign stg_clk[i] = clk;
      assign stg_jk[i]  = count_en;
    end else begin : g_rest
      // Each higher bit toggles when the bit below falls.
      assign stg_clk[i] = q[i-1];
      assign stg_jk[i]  = 1'b1;
    end
    jk_ff u_ff (
      .clk   (stg_clk[i]),
      .rst_n (rst_n),
      .j     (stg_jk[i]),
      .k     (stg_jk[i]),
      .pre_n (pre_n[i]),
      .clr_n (clr_n[i]),
      .q     (q[i]),
      .qbar  (qbar[i])
    );
  end

  logic [WIDTH-1:0] q_sync_q, q_sync_d;
  logic             wrap_q, wrap_d;
  logic             wrap_ok;

`ifdef ASYNC_CNT_LOAD_EN
  // Only a real counting edge may produce wrap, never a load.
  logic cnt_edge_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_edge_q <= 1'b0;
    end else begin
      cnt_edge_q <= count_en & ~load;
    end
  end

  assign wrap_ok = cnt_edge_q & ~load;
`else
  assign wrap_ok = 1'b1;
`endif

  assign q_sync_d = q;
  assign wrap_d   = wrap_ok
                  && (q_sync_q == ONES)
                  && (q_sync_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sync_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      q_sync_q <= q_sync_d;
      wrap_q   <= wrap_d;
    end
  end

  assign q_sync = q_sync_q;
  assign wrap   = wrap_q;

endmodule
